// File: rtl/shift_step_sequencer_if.sv
// Command/shifter bundle for shift_step_sequencer: command inputs, shifter drive and return, status/result.
// The master side issues commands and closes the shifter loop; the slave side is the sequencer.
interface shift_step_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int AMT_W   = 2,
  parameter int TOTAL_W = 4
);
  logic               start_i;
  logic [WIDTH-1:0]   data_i;
  logic [TOTAL_W-1:0] total_i;
  logic               dir_i;
  logic               clear_i;
  logic [WIDTH-1:0]   bs_data_o;
  logic [AMT_W-1:0]   bs_amt_o;
  logic               bs_dir_o;
  logic [WIDTH-1:0]   bs_result_i;
  logic               busy_o;
  logic               done_o;
  logic [WIDTH-1:0]   result_o;

  modport master (
    output start_i, data_i, total_i, dir_i, clear_i, bs_result_i,
    input  bs_data_o, bs_amt_o, bs_dir_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, data_i, total_i, dir_i, clear_i, bs_result_i,
    output bs_data_o, bs_amt_o, bs_dir_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/shift_step_sequencer.sv
// Splits one large shift command into passes of at most 2**AMT_W-1 through an external
// barrel shifter, feeding each pass result back until the full amount has been applied.
module shift_step_sequencer #(
  parameter int WIDTH   = 4,
  parameter int AMT_W   = 2,
  parameter int TOTAL_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  shift_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [TOTAL_W-1:0] MAX_STEP = TOTAL_W'((1 << AMT_W) - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_cur;
  logic [TOTAL_W-1:0] r_rem;
  logic               r_dir;
  logic [WIDTH-1:0]   r_result;
  logic [TOTAL_W-1:0] w_step;

  // Per-pass amount: the remaining distance, capped at the shifter's maximum step.
  always_comb begin
    w_step = r_rem;
    if (r_rem > MAX_STEP) begin
      w_step = MAX_STEP;
    end else begin
      w_step = r_rem;
    end
  end

  // Shifter amount is non-zero only while running, so idle passes are transparent.
  always_comb begin
    bus.bs_amt_o = {AMT_W{1'b0}};
    if (r_state == ST_RUN) begin
      bus.bs_amt_o = w_step[AMT_W-1:0];
    end else begin
      bus.bs_amt_o = {AMT_W{1'b0}};
    end
  end

  assign bus.bs_data_o = r_cur;
  assign bus.bs_dir_o  = r_dir;
  assign bus.busy_o    = (r_state == ST_RUN);
  assign bus.done_o    = (r_state == ST_DONE);
  assign bus.result_o  = r_result;

  // Command FSM; clear aborts without touching the previously published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cur    <= {WIDTH{1'b0}};
      r_rem    <= {TOTAL_W{1'b0}};
      r_dir    <= 1'b0;
      r_result <= {WIDTH{1'b0}};
    end else if (bus.clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            r_cur <= bus.data_i;
            r_rem <= bus.total_i;
            r_dir <= bus.dir_i;
            if (bus.total_i == {TOTAL_W{1'b0}}) begin
              r_result <= bus.data_i;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_cur <= bus.bs_result_i;
          r_rem <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_result <= bus.bs_result_i;
            r_state  <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_step_sequencer.sv
// Self-checking bench for shift_step_sequencer: closes the loop with a 4-bit rotate shifter
// and compares against a whole-command rotate reference and a table of hand-computed results.
module tb_shift_step_sequencer;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] last_result;

  shift_step_sequencer_if #(.WIDTH(4), .AMT_W(2), .TOTAL_W(4)) bus ();

  shift_step_sequencer #(.WIDTH(4), .AMT_W(2), .TOTAL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] shifter_model(input logic [3:0] v, input logic [1:0] a, input logic dr);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < int'(a); i++) begin
      r = dr ? {r[0], r[3:1]} : {r[2:0], r[3]};
    end
    return r;
  endfunction

  assign bus.bs_result_i = shifter_model(bus.bs_data_o, bus.bs_amt_o, bus.bs_dir_o);

  // Whole-command reference: a rotate by the total amount, reduced modulo the word width.
  function automatic logic [3:0] expect_rot(input int d, input int t, input logic dr);
    int k;
    int v;
    k = t % 4;
    if (dr) k = (4 - k) % 4;
    v = ((d << k) | (d >> (4 - k))) & 15;
    return v[3:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and follows it to its done pulse (or the clear abort).
  // ghost_cyc: cycle in which a stray start is pulsed; clr_cyc: cycle in which clear is raised.
  task automatic do_cmd(input logic [3:0] d, input logic [3:0] t, input logic dr,
                        input int ghost_cyc, input int clr_cyc, input string tag);
    int exp_amts[$];
    int rem;
    int stp;
    int cyc;
    int seen;
    int exp_lat;
    logic [3:0] exp_res;
    rem = int'(t);
    while (rem > 0) begin
      stp = (rem > 3) ? 3 : rem;
      exp_amts.push_back(stp);
      rem -= stp;
    end
    exp_lat = (int'(t) + 2) / 3 + 1;
    exp_res = expect_rot(int'(d), int'(t), dr);

    bus.start_i = 1'b1;
    bus.data_i  = d;
    bus.total_i = t;
    bus.dir_i   = dr;
    tick();
    bus.start_i = 1'b0;
    cyc  = 1;
    seen = 0;
    while (bus.done_o !== 1'b1 && cyc < 24) begin
      if (cyc == clr_cyc) begin
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check({tag, "_clr_busy"}, bus.busy_o, 1'b0);
        check({tag, "_clr_done"}, bus.done_o, 1'b0);
        check({tag, "_clr_result"}, bus.result_o, last_result);
        repeat (3) begin
          tick();
          check({tag, "_clr_nodone"}, bus.done_o, 1'b0);
        end
        return;
      end
      if (bus.busy_o === 1'b1) begin
        if (seen < exp_amts.size()) check({tag, "_amt"}, bus.bs_amt_o, exp_amts[seen]);
        seen++;
      end else begin
        check({tag, "_amt_idle"}, bus.bs_amt_o, 2'd0);
      end
      if (cyc == ghost_cyc) begin
        bus.start_i = 1'b1;
        bus.data_i  = ~d;
        bus.total_i = 4'd1;
        bus.dir_i   = ~dr;
      end
      tick();
      bus.start_i = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_done"}, bus.done_o, 1'b1);
    check({tag, "_busy_at_done"}, bus.busy_o, 1'b0);
    check({tag, "_amt_at_done"}, bus.bs_amt_o, 2'd0);
    check({tag, "_passes"}, seen, exp_amts.size());
    check({tag, "_result"}, bus.result_o, exp_res);
    last_result = exp_res;
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] total;
    logic       dir;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    checks      = 0;
    errors      = 0;
    last_result = 4'd0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.data_i  = 4'd0;
    bus.total_i = 4'd0;
    bus.dir_i   = 1'b0;
    bus.clear_i = 1'b0;

    vecs[0] = '{4'b0001, 4'd7,  LEFT,  4'b1000};
    vecs[1] = '{4'hA,    4'd0,  LEFT,  4'hA};
    vecs[2] = '{4'b0001, 4'd15, RIGHT, 4'b0010};
    vecs[3] = '{4'b1001, 4'd4,  LEFT,  4'b1001};
    vecs[4] = '{4'b0011, 4'd5,  RIGHT, 4'b1001};
    vecs[5] = '{4'b0110, 4'd2,  LEFT,  4'b1001};
    vecs[6] = '{4'b1100, 4'd9,  LEFT,  4'b1001};
    vecs[7] = '{4'b0101, 4'd13, RIGHT, 4'b1010};
    vecs[8] = '{4'b1000, 4'd3,  RIGHT, 4'b0001};

    // Reset values while held, then after release with no command.
    #3;
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_amt", bus.bs_amt_o, 2'd0);
    check("rst_result", bus.result_o, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_busy", bus.busy_o, 1'b0);
    check("rel_done", bus.done_o, 1'b0);
    check("rel_amt", bus.bs_amt_o, 2'd0);
    check("rel_result", bus.result_o, 4'd0);

    for (int i = 0; i < 9; i++) begin
      do_cmd(vecs[i].data, vecs[i].total, vecs[i].dir, 0, 0, "tbl");
      check("tbl_expected", bus.result_o, vecs[i].exp_res);
      tick();
      check("tbl_done_one_cycle", bus.done_o, 1'b0);
      check("tbl_result_held", bus.result_o, vecs[i].exp_res);
    end

    // Stray start during RUN is ignored.
    do_cmd(4'b0001, 4'd15, RIGHT, 2, 0, "ghost");
    check("ghost_result", bus.result_o, 4'b0010);
    tick();

    // Clear in the second RUN cycle of a total=9 command.
    do_cmd(4'b0111, 4'd9, LEFT, 0, 2, "clear");

    // Reset dropped mid-RUN takes effect before the next edge.
    bus.start_i = 1'b1;
    bus.data_i  = 4'b0110;
    bus.total_i = 4'd12;
    bus.dir_i   = LEFT;
    tick();
    bus.start_i = 1'b0;
    tick();
    check("mid_busy_before", bus.busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_amt", bus.bs_amt_o, 2'd0);
    check("mid_rst_result", bus.result_o, 4'd0);
    check("mid_rst_done", bus.done_o, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    last_result = 4'd0;
    do_cmd(4'b0011, 4'd6, LEFT, 0, 0, "after_rst");

    // Back-to-back: new start accepted in the DONE cycle.
    do_cmd(4'b1010, 4'd1, RIGHT, 0, 0, "b2b");
    do_cmd(4'b1110, 4'd0, LEFT, 0, 0, "b2b_zero");
    tick();
    check("b2b_done_low", bus.done_o, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             0, 0, "rand");
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rand_done_low", bus.done_o, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
